// File: rtl/ram_stream_loader_pkg.sv
// Shared types and constants for the RAM stream loader.
package ram_stream_loader_pkg;

  localparam int unsigned DEF_ADDRESS_SIZE = 4;
  localparam int unsigned DEF_WORD_SIZE    = 32;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ram_stream_outreg.sv
// DUMP output register: captures a RAM word and holds it until the sink takes it.
module ram_stream_outreg #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [WORD_SIZE-1:0] din,
  output logic                 valid,
  output logic [WORD_SIZE-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_stream_loader.sv
// Command-driven LOAD/DUMP streamer between valid/ready streams and the state RAM.
// Define RAM_STREAM_LOADER_CHECKSUM_EN to add a running checksum output.
module ram_stream_loader
  import ram_stream_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [ADDRESS_SIZE-1:0] cmd_base,
  input  logic [ADDRESS_SIZE:0]   cmd_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_SIZE-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_SIZE-1:0]    out_data,
  output logic                    ram_we1,
  output logic [ADDRESS_SIZE-1:0] ram_addr1,
  output logic [WORD_SIZE-1:0]    ram_wdata,
  output logic [ADDRESS_SIZE-1:0] ram_addr2,
  input  logic [WORD_SIZE-1:0]    ram_rdata,
  output logic                    busy,
  output logic                    done
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_SIZE-1:0]    checksum
`endif
);

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] ptr;
  logic [ADDRESS_SIZE:0]   remaining;
  logic                    op;
  logic                    out_load;
  logic                    out_clear;

  assign cmd_ready = (state == IDLE);
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign ram_we1   = (state == LOAD) && (op == OP_LOAD) && in_valid;
  assign ram_addr1 = ptr;
  assign ram_wdata = in_data;
  assign ram_addr2 = ptr;

  // Refill the output register whenever it is empty or being drained this cycle.
  assign out_load  = (state == DUMP) && (remaining != '0) && (!out_valid || out_ready);
  assign out_clear = (state == DUMP) && out_valid && out_ready;

  ram_stream_outreg #(
    .WORD_SIZE (WORD_SIZE)
  ) u_outreg (
    .clk   (clk),
    .rst   (rst),
    .load  (out_load),
    .clear (out_clear),
    .din   (ram_rdata),
    .valid (out_valid),
    .data  (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      op        <= OP_LOAD;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr       <= cmd_base;
            remaining <= cmd_len;
            op        <= cmd_op;
            if (cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= (cmd_op == OP_DUMP) ? DUMP : LOAD;
            end
          end
        end
        LOAD: begin
          if (ram_we1) begin
            ptr       <= ptr + ADDRESS_SIZE'(1);
            remaining <= remaining - (ADDRESS_SIZE + 1)'(1);
            if (remaining == (ADDRESS_SIZE + 1)'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DUMP: begin
          if (out_load) begin
            ptr       <= ptr + ADDRESS_SIZE'(1);
            remaining <= remaining - (ADDRESS_SIZE + 1)'(1);
          end else if (out_clear && (remaining == '0)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
  // Sum of every word moved by the current command, cleared on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && cmd_valid) begin
      checksum <= '0;
    end else if (ram_we1) begin
      checksum <= checksum + in_data;
    end else if (out_clear) begin
      checksum <= checksum + out_data;
    end
  end
`endif

endmodule
